// File: rtl/cpu_pkg.sv
// Shared definitions for the R-type-only single-cycle MIPS core.
// Holds the opcode/funct encodings, the ALU operation enum and the
// funct -> operation mapping used by the ALU.
package cpu_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_NOR = 6'h27;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_NONE,
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_NOR,
        ALU_SLT
    } alu_op_t;

    // Any funct outside the supported set maps to ALU_NONE (result 0, no write).
    function automatic alu_op_t funct_to_op(input logic [5:0] funct);
        case (funct)
            FUNCT_ADD: return ALU_ADD;
            FUNCT_SUB: return ALU_SUB;
            FUNCT_AND: return ALU_AND;
            FUNCT_OR:  return ALU_OR;
            FUNCT_NOR: return ALU_NOR;
            FUNCT_SLT: return ALU_SLT;
            default:   return ALU_NONE;
        endcase
    endfunction

endpackage

// File: rtl/alu_r.sv
// R-type ALU: maps funct to an operation and computes a 32-bit result with
// wrap-around arithmetic. Unsupported funct, or en_i low (not an R-type
// opcode), gives result 0 and valid_o low.
// Ports:
//   en_i      instruction is R-type
//   funct_i   funct field
//   a_i, b_i  rs / rt operands
//   result_o  ALU result
//   valid_o   funct is a supported operation
module alu_r
    import cpu_pkg::*;
(
    input  logic              en_i,
    input  logic [5:0]        funct_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              valid_o
);

    alu_op_t op;

    always_comb begin
        op       = en_i ? funct_to_op(funct_i) : ALU_NONE;
        result_o = '0;
        case (op)
            ALU_ADD: result_o = a_i + b_i;
            ALU_SUB: result_o = a_i - b_i;
            ALU_AND: result_o = a_i & b_i;
            ALU_OR:  result_o = a_i | b_i;
            ALU_NOR: result_o = ~(a_i | b_i);
            ALU_SLT: result_o = {{(DATA_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            default: result_o = '0;
        endcase
        valid_o = (op != ALU_NONE);
    end

endmodule

// File: rtl/cpu_im.sv
// Instruction memory: IM_DEPTH x 32-bit words, asynchronous read.
// Contents are preloaded into instBank before reset is released. The load
// port exists so the array has a writer; the CPU top ties it off.
// Ports:
//   clk_i      load clock
//   ld_en_i    load enable (tied low in the CPU)
//   ld_addr_i  load word index
//   ld_data_i  load data
//   addr_i     read word index
//   inst_o     instruction word at addr_i
module cpu_im #(
    parameter int IM_DEPTH = 64,
    parameter int AW       = $clog2(IM_DEPTH)
) (
    input  logic          clk_i,
    input  logic          ld_en_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [31:0]   ld_data_i,
    input  logic [AW-1:0] addr_i,
    output logic [31:0]   inst_o
);

    reg [31:0] instBank [0:IM_DEPTH-1];

    always @(posedge clk_i) begin
        if (ld_en_i) instBank[ld_addr_i] <= ld_data_i;
    end

    assign inst_o = instBank[addr_i];

endmodule

// File: rtl/cpu_rb.sv
// Register bank: RB_DEPTH x 32-bit, two asynchronous read ports and one
// synchronous write port. Register 0 reads as zero and is never written.
// Contents are not cleared by reset; a write is simply blocked on any edge
// where reset is held low.
// Ports:
//   clk_i   write clock
//   rst_ni  active-low reset (write inhibit)
//   ra1_i   read address 1  -> rd1_o
//   ra2_i   read address 2  -> rd2_o
//   we_i    write enable
//   wa_i    write address
//   wd_i    write data
module cpu_rb #(
    parameter int RB_DEPTH = 32,
    parameter int AW       = $clog2(RB_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [AW-1:0] ra1_i,
    input  logic [AW-1:0] ra2_i,
    output logic [31:0]   rd1_o,
    output logic [31:0]   rd2_o,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [31:0]   wd_i
);

    reg [31:0] registerBank [0:RB_DEPTH-1];

    // Reads are combinational from the array, so a same-cycle read of the
    // register being written sees the old value until the edge.
    always @(posedge clk_i) begin
        if (rst_ni && we_i && (wa_i != '0)) registerBank[wa_i] <= wd_i;
    end

    assign rd1_o = (ra1_i == '0) ? 32'd0 : registerBank[ra1_i];
    assign rd2_o = (ra2_i == '0) ? 32'd0 : registerBank[ra2_i];

endmodule

// File: rtl/cpu_control_r_type.sv
// Single-cycle MIPS core executing R-type instructions only.
// Fetches from IM at PC, reads rs/rt from BR, runs alu_r and writes the
// result to rd on the next rising edge. resultado is the combinational ALU
// result of the instruction currently addressed by the PC.
// Ports:
//   clk_CPU    system clock, rising edge
//   rst_CPU_n  asynchronous active-low reset (PC -> 0, writes blocked)
//   resultado  ALU result of the current instruction
module cpu_control_r_type
    import cpu_pkg::*;
#(
    parameter int IM_DEPTH = 64,
    parameter int RB_DEPTH = 32
) (
    input  logic              clk_CPU,
    input  logic              rst_CPU_n,
    output logic [DATA_W-1:0] resultado
);

    localparam int IM_AW = $clog2(IM_DEPTH);
    localparam int RB_AW = $clog2(RB_DEPTH);

    logic [31:0]       pc_q, pc_d;
    logic [31:0]       inst;
    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd;
    logic [DATA_W-1:0] rs_val, rt_val;
    logic              is_rtype, alu_valid, reg_write;
    logic [4:0]        unused_shamt;

    assign pc_d = pc_q + 32'd4;

    always_ff @(posedge clk_CPU or negedge rst_CPU_n) begin
        if (!rst_CPU_n) pc_q <= '0;
        else            pc_q <= pc_d;
    end

    // Word index drops the byte offset; the upper PC bits are ignored so the
    // fetch wraps after the last word.
    cpu_im #(.IM_DEPTH(IM_DEPTH)) IM (
        .clk_i     (clk_CPU),
        .ld_en_i   (1'b0),
        .ld_addr_i ('0),
        .ld_data_i ('0),
        .addr_i    (pc_q[IM_AW+1:2]),
        .inst_o    (inst)
    );

    assign op           = inst[31:26];
    assign rs           = inst[25:21];
    assign rt           = inst[20:16];
    assign rd           = inst[15:11];
    assign unused_shamt = inst[10:6];
    assign funct        = inst[5:0];

    assign is_rtype  = (op == OP_RTYPE);
    assign reg_write = is_rtype && alu_valid && (rd != 5'd0);

    cpu_rb #(.RB_DEPTH(RB_DEPTH)) BR (
        .clk_i  (clk_CPU),
        .rst_ni (rst_CPU_n),
        .ra1_i  (rs[RB_AW-1:0]),
        .ra2_i  (rt[RB_AW-1:0]),
        .rd1_o  (rs_val),
        .rd2_o  (rt_val),
        .we_i   (reg_write),
        .wa_i   (rd[RB_AW-1:0]),
        .wd_i   (resultado)
    );

    alu_r u_alu (
        .en_i     (is_rtype),
        .funct_i  (funct),
        .a_i      (rs_val),
        .b_i      (rt_val),
        .result_o (resultado),
        .valid_o  (alu_valid)
    );

endmodule

// File: tb/tb_cpu_control_r_type.sv
// Randomized self-checking bench for cpu_control_r_type: directed program
// prefix with constant expectations, random remainder, and a reference model
// of the architectural state (PC, register array, instruction array).
module tb_cpu_control_r_type;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] resultado;

    cpu_control_r_type dut (
        .clk_CPU   (clk),
        .rst_CPU_n (rst_n),
        .resultado (resultado)
    );

    always #10 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_im [64];
    logic [31:0] m_rf [32];
    int unsigned m_pc;
    logic [31:0] exp_dir [13];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input int rs, input int rt, input int rd, input logic [5:0] f);
        logic [4:0] s, t, d;
        s = rs[4:0]; t = rt[4:0]; d = rd[4:0];
        return {6'd0, s, t, d, 5'd0, f};
    endfunction

    function automatic bit supported(input logic [5:0] f);
        return f == 6'h20 || f == 6'h22 || f == 6'h24 || f == 6'h25 || f == 6'h27 || f == 6'h2A;
    endfunction

    // Architectural result of one instruction against the model register file.
    function automatic logic [31:0] ref_res(input logic [31:0] ins);
        logic [31:0] a, b;
        a = m_rf[ins[25:21]];
        b = m_rf[ins[20:16]];
        if (ins[31:26] != 6'd0) return 32'd0;
        case (ins[5:0])
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h27: return ~(a | b);
            6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    // Run n cycles starting on a negedge; ends on a negedge.
    task automatic run(input int n, input bit directed);
        logic [31:0] ins, exp;
        logic [4:0]  rd;
        bit          wr;
        int          w;
        for (int c = 0; c < n; c++) begin
            w   = int'((m_pc >> 2) % 64);
            ins = m_im[w];
            exp = ref_res(ins);
            chk($sformatf("res c%0d w%0d", c, w), resultado, exp);
            if (directed && c < 13) chk($sformatf("dir w%0d", c), resultado, exp_dir[c]);
            rd = ins[15:11];
            wr = (ins[31:26] == 6'd0) && supported(ins[5:0]) && (rd != 5'd0);
            @(posedge clk);
            #1;
            if (wr) m_rf[rd] = exp;
            m_pc += 4;
            chk($sformatf("rf c%0d r%0d", c, rd), dut.BR.registerBank[rd], m_rf[rd]);
            @(negedge clk);
        end
    endtask

    initial begin
        int r;
        // Register file: fixed operands for the directed prefix, random elsewhere.
        for (int i = 0; i < 32; i++) m_rf[i] = $urandom;
        m_rf[0] = 32'd0;
        m_rf[1] = 32'd5;
        m_rf[2] = 32'd7;
        m_rf[6] = 32'hF0F0F0F0;
        m_rf[7] = 32'h0FF00FF0;

        m_im[0]  = enc(1, 2, 3, 6'h20);              // add $3,$1,$2
        m_im[1]  = enc(1, 2, 4, 6'h22);              // sub $4,$1,$2
        m_im[2]  = enc(1, 2, 5, 6'h2A);              // slt $5,$1,$2
        m_im[3]  = enc(2, 1, 5, 6'h2A);              // slt $5,$2,$1
        m_im[4]  = enc(6, 7, 9, 6'h24);              // and
        m_im[5]  = enc(6, 7, 10, 6'h25);             // or
        m_im[6]  = enc(6, 7, 11, 6'h27);             // nor
        m_im[7]  = enc(3, 3, 8, 6'h20);              // add $8,$3,$3
        m_im[8]  = enc(1, 2, 0, 6'h20);              // add $0,$1,$2
        m_im[9]  = enc(1, 2, 12, 6'h08);             // unsupported funct
        m_im[10] = {6'h08, 5'd1, 5'd2, 5'd12, 5'd0, 6'h20}; // non-R opcode
        m_im[11] = 32'h00000000;                     // nop
        m_im[12] = enc(0, 3, 12, 6'h20);             // add $12,$0,$3
        exp_dir = '{32'd12, 32'hFFFFFFFE, 32'd1, 32'd0, 32'h00F000F0, 32'hFFF0FFF0,
                    32'h000F000F, 32'd24, 32'd12, 32'd0, 32'd0, 32'd0, 32'd12};

        for (int w = 13; w < 64; w++) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                m_im[w] = $urandom;
                if (m_im[w][31:26] == 6'd0) m_im[w][31:26] = 6'h23;
            end else if (r == 1) begin
                m_im[w] = enc($urandom_range(0, 31), $urandom_range(0, 31),
                              $urandom_range(1, 31), 6'h26);
            end else begin
                case ($urandom_range(0, 5))
                    0: m_im[w] = enc($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 6'h20);
                    1: m_im[w] = enc($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 6'h22);
                    2: m_im[w] = enc($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 6'h24);
                    3: m_im[w] = enc($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 6'h25);
                    4: m_im[w] = enc($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 6'h27);
                    default: m_im[w] = enc($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), 6'h2A);
                endcase
            end
        end

        for (int i = 0; i < 64; i++) dut.IM.instBank[i] = m_im[i];
        for (int i = 0; i < 32; i++) dut.BR.registerBank[i] = m_rf[i];
        m_pc = 0;

        // Reset held across edges: stays on word 0, no register write.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rst res c%0d", c), resultado, 32'd12);
            @(posedge clk);
            #1;
            chk($sformatf("rst r3 c%0d", c), dut.BR.registerBank[3], m_rf[3]);
        end
        @(negedge clk);
        rst_n = 1'b1;

        run(200, 1'b1);

        // Reset asserted mid-cycle: PC clears immediately, the edge's write is blocked.
        #5;
        rst_n = 1'b0;
        m_pc = 0;
        #1;
        chk("async rst res", resultado, ref_res(m_im[0]));
        @(posedge clk);
        #1;
        for (int i = 0; i < 32; i++) chk($sformatf("async rst r%0d", i), dut.BR.registerBank[i], m_rf[i]);
        @(negedge clk);
        rst_n = 1'b1;

        run(20, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
